qdrc_phy_autocal: RTL and testbench

QDRC_PHY_AUTOCAL -- requirements
Module: qdrc_phy_autocal

---
 rtl/qdrc_phy_autocal.sv | 134 +++++++++++++
 tb/tb_qdrc_phy_autocal.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/qdrc_phy_autocal.sv
// qdrc_phy_autocal: per-lane QDR read-capture IDELAY sweep and window centring.
// Define QDRC_AUTOCAL_FALL_CHECK_EN to also require qdr_q_fall==0 for a passing tap.
module qdrc_phy_autocal #(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 21,
  parameter int TAPS         = 32,
  parameter int READ_LATENCY = 10,
  parameter int SETTLE       = 8,
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cal_start,
  output logic                  cal_busy,
  output logic                  cal_done,
  output logic                  cal_fail,
  output logic [BW-1:0]         cal_bit,
  output logic [ADDR_WIDTH-1:0] qdr_sa,
  output logic                  qdr_w_n,
  output logic                  qdr_r_n,
  output logic [DATA_WIDTH-1:0] qdr_d_rise,
  output logic [DATA_WIDTH-1:0] qdr_d_fall,
  input  logic [DATA_WIDTH-1:0] qdr_q_rise,
  input  logic [DATA_WIDTH-1:0] qdr_q_fall,
  output logic [DATA_WIDTH-1:0] dly_en,
  output logic [DATA_WIDTH-1:0] dly_inc_dec_n,
  output logic [DATA_WIDTH-1:0] dly_rst
);
  localparam int TW   = $clog2(TAPS);
  localparam int CMAX = (SETTLE > READ_LATENCY) ? SETTLE : READ_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [3:0] {
    IDLE, WRITE, RST, WAIT, READ, LAT, SAMPLE, INC, CRST, CINC, NEXT, DONE
  } state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tap, r_first, r_last, r_center;
  logic              r_found, r_closed, r_fail;
  logic [BW-1:0]     r_bit;
  logic              w_pass, w_closed_nx, w_settled, w_inc, w_cnt_en;
  logic [TW:0]       w_sum;
  logic [DATA_WIDTH-1:0] w_sel;
`ifdef QDRC_AUTOCAL_FALL_CHECK_EN
  assign w_pass = qdr_q_rise[r_bit] & ~qdr_q_fall[r_bit];
`else
  logic w_unused;
  assign w_unused = ^qdr_q_fall;
  assign w_pass   = qdr_q_rise[r_bit];
`endif
  // A fail after the first passing run closes the window for the rest of the sweep
  assign w_closed_nx = r_closed | (r_found & ~w_pass);
  assign w_settled   = r_cnt >= CW'(SETTLE);
  assign w_inc       = (r_state == INC) || (r_state == CINC && w_settled && r_tap != r_center);
  assign w_cnt_en    = (r_state == WAIT) || (r_state == LAT) || (r_state == CINC && !w_settled);
  assign w_sum       = {1'b0, r_first} + {1'b0, r_last};
  assign w_sel       = DATA_WIDTH'(1) << r_bit;
  assign dly_en        = w_inc ? w_sel : '0;
  assign dly_inc_dec_n = w_inc ? w_sel : '0;
  assign dly_rst       = (r_state == RST || r_state == CRST) ? w_sel : '0;
  assign qdr_sa     = '0;
  assign qdr_w_n    = r_state != WRITE;
  assign qdr_r_n    = r_state != READ;
  assign qdr_d_rise = '1;
  assign qdr_d_fall = '0;
  assign cal_busy   = !(r_state == IDLE || r_state == DONE);
  assign cal_done   = r_state == DONE;
  assign cal_fail   = r_fail;
  assign cal_bit    = r_bit;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = cal_start ? WRITE : r_state;
      WRITE:      w_next = RST;
      RST:        w_next = WAIT;
      WAIT:       w_next = (r_cnt == CW'(SETTLE - 1)) ? READ : WAIT;
      READ:       w_next = (READ_LATENCY > 1) ? LAT : SAMPLE;
      LAT:        w_next = (r_cnt == CW'(READ_LATENCY - 2)) ? SAMPLE : LAT;
      SAMPLE:     w_next = (r_tap != TW'(TAPS - 1) && !w_closed_nx) ? INC : CRST;
      INC:        w_next = WAIT;
      CRST:       w_next = CINC;
      CINC:       w_next = (w_settled && r_tap == r_center) ? NEXT : CINC;
      NEXT:       w_next = (r_bit == BW'(DATA_WIDTH - 1)) ? DONE : RST;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tap    <= '0;
      r_first  <= '0;
      r_last   <= '0;
      r_center <= '0;
      r_found  <= 1'b0;
      r_closed <= 1'b0;
      r_fail   <= 1'b0;
      r_bit    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(w_cnt_en);
      case (r_state)
        WRITE: begin
          r_fail <= 1'b0;
          r_bit  <= '0;
        end
        RST: begin
          r_tap    <= '0;
          r_first  <= '0;
          r_last   <= '0;
          r_found  <= 1'b0;
          r_closed <= 1'b0;
        end
        SAMPLE: begin
          if (w_pass && !r_found) begin
            r_first <= r_tap;
            r_last  <= r_tap;
            r_found <= 1'b1;
          end else if (w_pass && !r_closed) r_last <= r_tap;
          r_closed <= w_closed_nx;
        end
        INC:  r_tap <= r_tap + TW'(1);
        // Tap counter is reused to count centring pulses after the line is reset
        CRST: begin
          r_tap    <= '0;
          r_center <= r_found ? w_sum[TW:1] : '0;
          r_fail   <= r_fail | ~r_found;
        end
        CINC: r_tap <= w_inc ? r_tap + TW'(1) : r_tap;
        NEXT: r_bit <= (r_bit == BW'(DATA_WIDTH - 1)) ? r_bit : r_bit + BW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qdrc_phy_autocal.sv
// tb_qdrc_phy_autocal: directed vectors against a per-lane IDELAY/pass-window model.
module tb_qdrc_phy_autocal;
  localparam int DW = 4, TP = 16, RL = 4, ST = 3, AW = 21;
  logic          clk = 1'b0, reset = 1'b1, cal_start = 1'b0;
  logic          cal_busy, cal_done, cal_fail, qdr_w_n, qdr_r_n;
  logic [1:0]    cal_bit;
  logic [AW-1:0] qdr_sa;
  logic [DW-1:0] qdr_d_rise, qdr_d_fall, qdr_q_rise, qdr_q_fall, dly_en, dly_inc_dec_n, dly_rst;
  always #5 clk = ~clk;
  qdrc_phy_autocal #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(TP), .READ_LATENCY(RL), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .cal_start(cal_start), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_fail(cal_fail), .cal_bit(cal_bit), .qdr_sa(qdr_sa), .qdr_w_n(qdr_w_n), .qdr_r_n(qdr_r_n),
    .qdr_d_rise(qdr_d_rise), .qdr_d_fall(qdr_d_fall), .qdr_q_rise(qdr_q_rise), .qdr_q_fall(qdr_q_fall),
    .dly_en(dly_en), .dly_inc_dec_n(dly_inc_dec_n), .dly_rst(dly_rst));
  typedef struct {
    logic [63:0] masks;
    logic [3:0]  fbad;
    logic [15:0] ecin;
    logic [15:0] eswp;
    logic        efail;
  } vec_t;
  vec_t        vecs [5];
  logic [15:0] mask [DW];
  logic [DW-1:0] fbad;
  logic [3:0]  m_tap [DW];
  int          rstn [DW], swp [DW], cin [DW];
  int          viol = 0, n_chk = 0, n_pass = 0;
  // Lane passes when its mask bit at the current model tap is set; fbad forces fall high
  always_comb begin
    qdr_q_rise = '0;
    qdr_q_fall = '0;
    for (int l = 0; l < DW; l++) begin
      qdr_q_rise[l] = fbad[l] | mask[l][m_tap[l]];
      qdr_q_fall[l] = fbad[l] | ~mask[l][m_tap[l]];
    end
  end
  // Pulses after a lane's first reset are sweep steps, after its second are centring steps
  always @(negedge clk) begin
    if (cal_start && !cal_busy)
      for (int l = 0; l < DW; l++) begin
        rstn[l] <= 0;
        swp[l]  <= 0;
        cin[l]  <= 0;
      end
    for (int l = 0; l < DW; l++)
      if (dly_rst[l]) begin
        m_tap[l] <= 4'd0;
        rstn[l]  <= rstn[l] + 1;
      end else if (dly_en[l]) begin
        m_tap[l] <= dly_inc_dec_n[l] ? m_tap[l] + 4'd1 : m_tap[l] - 4'd1;
        if (rstn[l] == 1) swp[l] <= swp[l] + 1;
        else cin[l] <= cin[l] + 1;
      end
    if ($countones(dly_en) + $countones(dly_rst) > 1 || dly_inc_dec_n != dly_en) viol <= viol + 1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic load(input int v);
    for (int l = 0; l < DW; l++) mask[l] = vecs[v].masks[16*l +: 16];
    fbad = vecs[v].fbad;
  endtask
  task automatic run_cal(input bit poke);
    int k = 0;
    logic [1:0] b;
    @(posedge clk); #1 cal_start = 1'b1;
    @(posedge clk); #1 cal_start = 1'b0;
    @(negedge clk);
    chk("start_busy", cal_busy, 1);
    chk("start_done_clr", cal_done, 0);
    if (poke) begin
      repeat (50) @(negedge clk);
      b = cal_bit;
      @(posedge clk); #1 cal_start = 1'b1;
      @(posedge clk); #1 cal_start = 1'b0;
      @(negedge clk);
      chk("poke_busy", cal_busy, 1);
      chk("poke_bit", cal_bit, b);
      chk("poke_no_rst", rstn[0], 1);
    end
    while (!cal_done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("cal_done_wait", cal_done, 1);
  endtask
  task automatic check_vec(input int v);
    chk($sformatf("v%0d done", v), cal_done, 1);
    chk($sformatf("v%0d busy", v), cal_busy, 0);
    chk($sformatf("v%0d fail", v), cal_fail, vecs[v].efail);
    for (int l = 0; l < DW; l++) begin
      chk($sformatf("v%0d lane%0d cinc", v, l), cin[l], vecs[v].ecin[4*l +: 4]);
      chk($sformatf("v%0d lane%0d sweep", v, l), swp[l], vecs[v].eswp[4*l +: 4]);
    end
    chk($sformatf("v%0d dly_onehot", v), viol, 0);
  endtask
  initial begin
    int k;
    vecs[0] = '{{4{16'h0FE0}}, 4'h0, 16'h8888, 16'hCCCC, 1'b0};
    vecs[1] = '{{16'h0FE0, 16'h0000, 16'h0FE0, 16'h0FE0}, 4'h0, 16'h8088, 16'hCFCC, 1'b1};
    vecs[2] = '{{16'h0FE0, 16'h0FE0, 16'h0FE0, 16'h1E1C}, 4'h0, 16'h8883, 16'hCCC5, 1'b0};
    vecs[3] = '{{16'h0001, 16'h0FE0, 16'h8000, 16'h0FE0}, 4'h0, 16'h08F8, 16'h1CFC, 1'b0};
`ifdef QDRC_AUTOCAL_FALL_CHECK_EN
    vecs[4] = '{{4{16'hFFFF}}, 4'hF, 16'h0000, 16'hFFFF, 1'b1};
`else
    vecs[4] = '{{4{16'hFFFF}}, 4'hF, 16'h7777, 16'hFFFF, 1'b0};
`endif
    for (int l = 0; l < DW; l++) m_tap[l] = 4'd0;
    load(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_fail", cal_fail, 0);
    chk("rst_bit", cal_bit, 0);
    chk("rst_w_n", qdr_w_n, 1);
    chk("rst_r_n", qdr_r_n, 1);
    chk("rst_dly", {dly_en, dly_inc_dec_n, dly_rst}, 0);
    chk("rst_d_rise", qdr_d_rise, 15);
    @(posedge clk); #1 reset = 1'b0;
    for (int v = 0; v < 5; v++) begin
      load(v);
      run_cal(v == 1);
      check_vec(v);
      if (v == 0) begin
        repeat (20) @(negedge clk);
        chk("done_held", cal_done, 1);
      end
    end
    load(0);
    @(posedge clk); #1 cal_start = 1'b1;
    @(posedge clk); #1 cal_start = 1'b0;
    k = 0;
    while (!(cal_bit == 2'd1 && !qdr_r_n) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("lane1_read_seen", qdr_r_n, 0);
    repeat (RL) @(posedge clk);
    #2;
    chk("pre_rst_bit", cal_bit, 1);
    chk("pre_rst_busy", cal_busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", cal_busy, 0);
    chk("mid_rst_bit", cal_bit, 0);
    chk("mid_rst_done", cal_done, 0);
    chk("mid_rst_qdr", {qdr_w_n, qdr_r_n}, 3);
    chk("mid_rst_dly", {dly_en, dly_inc_dec_n, dly_rst}, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_cal(1'b0);
    check_vec(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
